// File: rtl/vector_sd_dac.sv
// Multi-channel sigma-delta requantiser: wide unsigned samples in, narrower
// noise-shaped codes out, first order or MASH 1-1, with one-deep input buffering.
module vector_sd_dac #(
    parameter int CHANNELS = 3,
    parameter int IN_W     = 10,
    parameter int OUT_W    = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       blank,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*IN_W-1:0]  in_data,
    output logic [CHANNELS*OUT_W-1:0] out,
    output logic                      out_stb
);

    localparam int FRAC_W = IN_W - OUT_W;
    localparam int SW     = OUT_W + 2;
    localparam logic signed [SW-1:0] MAX_CODE = SW'((1 << OUT_W) - 1);

    logic [CHANNELS*IN_W-1:0] pend;
    logic [CHANNELS*IN_W-1:0] cur;
    logic                     pend_full;
    logic                     pend_full_nxt;
    logic                     accept;
    logic                     mode_r;
    logic [FRAC_W-1:0]        acc1     [CHANNELS];
    logic [FRAC_W-1:0]        acc2     [CHANNELS];
    logic [CHANNELS-1:0]      c2_prev;
    logic [FRAC_W-1:0]        acc1_nxt [CHANNELS];
    logic [FRAC_W-1:0]        acc2_nxt [CHANNELS];
    logic                     c2p_nxt  [CHANNELS];
    logic [OUT_W-1:0]         out_nxt  [CHANNELS];

    // Pending-buffer occupancy: an accept fills it, a ce drains it into cur.
    always_comb begin
        accept = in_valid & in_ready;
        if (accept) begin
            pend_full_nxt = 1'b1;
        end else if (ce) begin
            pend_full_nxt = 1'b0;
        end else begin
            pend_full_nxt = pend_full;
        end
    end

    // Per-channel modulator step computed from the current sample and state.
    always_comb begin : ch_next
        logic [OUT_W-1:0]      coarse;
        logic [FRAC_W-1:0]     frac;
        logic [FRAC_W:0]       s1;
        logic [FRAC_W:0]       s2;
        logic signed [SW-1:0]  level;
        coarse = '0;
        frac   = '0;
        s1     = '0;
        s2     = '0;
        level  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            coarse = cur[k*IN_W+FRAC_W +: OUT_W];
            frac   = cur[k*IN_W +: FRAC_W];
            s1     = {1'b0, acc1[k]} + {1'b0, frac};
            s2     = {1'b0, acc2[k]} + {1'b0, s1[FRAC_W-1:0]};
            level  = $signed({{(SW-OUT_W){1'b0}}, coarse}) + $signed({{(SW-1){1'b0}}, s1[FRAC_W]});
            if (mode) begin
                // MASH 1-1 correction: c2 minus its one-tick delayed copy.
                level = level + $signed({{(SW-1){1'b0}}, s2[FRAC_W]})
                              - $signed({{(SW-1){1'b0}}, c2_prev[k]});
            end else begin
                level = level;
            end
            acc1_nxt[k] = acc1[k];
            acc2_nxt[k] = acc2[k];
            c2p_nxt[k]  = c2_prev[k];
            out_nxt[k]  = '0;
            if (mode != mode_r) begin
                acc1_nxt[k] = '0;
                acc2_nxt[k] = '0;
                c2p_nxt[k]  = 1'b0;
                out_nxt[k]  = blank[k] ? {OUT_W{1'b0}} : coarse;
            end else if (blank[k]) begin
                out_nxt[k] = '0;
            end else begin
                acc1_nxt[k] = s1[FRAC_W-1:0];
                if (mode) begin
                    acc2_nxt[k] = s2[FRAC_W-1:0];
                    c2p_nxt[k]  = s2[FRAC_W];
                end else begin
                    acc2_nxt[k] = acc2[k];
                    c2p_nxt[k]  = c2_prev[k];
                end
                if (level[SW-1]) begin
                    out_nxt[k] = '0;
                end else if (level > MAX_CODE) begin
                    out_nxt[k] = MAX_CODE[OUT_W-1:0];
                end else begin
                    out_nxt[k] = level[OUT_W-1:0];
                end
            end
        end
    end

    // Buffer, modulator state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend      <= '0;
            cur       <= '0;
            pend_full <= 1'b0;
            in_ready  <= 1'b1;
            mode_r    <= 1'b0;
            out       <= '0;
            out_stb   <= 1'b0;
            c2_prev   <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                acc1[k] <= '0;
                acc2[k] <= '0;
            end
        end else begin
            if (accept) begin
                pend <= in_data;
            end
            pend_full <= pend_full_nxt;
            in_ready  <= ~pend_full_nxt;
            out_stb   <= ce;
            if (ce) begin
                if (pend_full) begin
                    cur <= pend;
                end
                mode_r <= mode;
                for (int k = 0; k < CHANNELS; k++) begin
                    acc1[k]                  <= acc1_nxt[k];
                    acc2[k]                  <= acc2_nxt[k];
                    c2_prev[k]               <= c2p_nxt[k];
                    out[k*OUT_W +: OUT_W]    <= out_nxt[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_sd_dac.sv
// Directed self-checking bench for vector_sd_dac (CHANNELS=3, IN_W=10, OUT_W=6).
module tb_vector_sd_dac;

    localparam int CHANNELS = 3;
    localparam int IN_W     = 10;
    localparam int OUT_W    = 6;

    logic                      clk;
    logic                      reset;
    logic                      ce;
    logic                      mode;
    logic [CHANNELS-1:0]       blank;
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*IN_W-1:0]  in_data;
    logic [CHANNELS*OUT_W-1:0] out;
    logic                      out_stb;

    int checks = 0;
    int errors = 0;
    int sum;
    logic [15:0] fo_mask;
    logic [31:0] v;

    vector_sd_dac #(.CHANNELS(CHANNELS), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .ce(ce), .mode(mode), .blank(blank),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out(out), .out_stb(out_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ch(input int k);
        return 32'(out[k*OUT_W +: OUT_W]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [CHANNELS*IN_W-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("accept_timeout", 32'(n < 50), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; mode = 1'b0; blank = '0;
        in_valid = 1'b0; in_data = '0;
        fo_mask = 16'h9248;
        step();
        check("rst_out", 32'(out), 32'd0);
        check("rst_stb", 32'(out_stb), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        // First order: ch0=0x105 -> 16 + 5/16, ch1 saturates high, ch2 zero.
        send({10'h000, 10'h3FF, 10'h105});
        check("fo_ready_low", 32'(in_ready), 32'd0);
        ce = 1'b1;
        step();
        check("fo_first_zero", 32'(out), 32'd0);
        check("fo_first_stb", 32'(out_stb), 32'd1);
        check("fo_ready_back", 32'(in_ready), 32'd1);
        sum = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            check("fo_ch0", ch(0), 32'd16 + 32'(fo_mask[4'(i)]));
            check("fo_ch1_sat", ch(1), 32'd63);
            check("fo_ch2_zero", ch(2), 32'd0);
            if (i < 16) sum += int'(ch(0));
        end
        check("fo_sum16", 32'(sum), 32'd261);

        // Blank ch0 for 7 ticks mid-pattern; the sequence must resume where it left off.
        for (int i = 0; i < 3; i++) begin
            step();
            check("bl_pre", ch(0), 32'd16 + 32'(fo_mask[4'(i)]));
        end
        blank = 3'b001;
        for (int i = 0; i < 7; i++) begin
            step();
            check("bl_zero", ch(0), 32'd0);
            check("bl_ch1", ch(1), 32'd63);
        end
        blank = 3'b000;
        for (int i = 3; i < 16; i++) begin
            step();
            check("bl_post", ch(0), 32'd16 + 32'(fo_mask[4'(i)]));
        end

        // ce low holds the output and drops the strobe.
        ce = 1'b0;
        step();
        check("hold_out", ch(0), 32'd17);
        check("hold_stb", 32'(out_stb), 32'd0);
        step();
        check("hold_out2", ch(0), 32'd17);

        // Handshake: A (ch0=0x200) then B (ch0=0x108) offered back-to-back with ce low.
        in_valid = 1'b1;
        in_data  = {10'h000, 10'h3FF, 10'h200};
        step();
        check("hs_a_accepted", 32'(in_ready), 32'd0);
        in_data  = {10'h000, 10'h3FF, 10'h108};
        step();
        check("hs_b_held", 32'(in_ready), 32'd0);
        ce = 1'b1;
        step();
        ce = 1'b0;
        check("hs_ready_rise", 32'(in_ready), 32'd1);
        check("hs_stb", 32'(out_stb), 32'd1);
        check("hs_old_cur", ch(0), 32'd16);
        step();
        in_valid = 1'b0;
        check("hs_b_accepted", 32'(in_ready), 32'd0);
        ce = 1'b1;
        step();
        check("hs_a_out", ch(0), 32'd32);
        check("hs_a_ch1", ch(1), 32'd63);
        check("hs_ready_again", 32'(in_ready), 32'd1);

        // Second order on B: mode change tick gives bare coarse, then 16,17,17,16 repeating.
        mode = 1'b1;
        step();
        check("so_modechg", ch(0), 32'd16);
        check("so_modechg_ch1", ch(1), 32'd63);
        sum = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            v = ch(0);
            check("so_range", 32'(v >= 32'd15 && v <= 32'd18), 32'd1);
            check("so_ch0", v, ((i % 4 == 1) || (i % 4 == 2)) ? 32'd17 : 32'd16);
            check("so_ch1_sat", ch(1), 32'd63);
            check("so_ch2_zero", ch(2), 32'd0);
            sum += int'(v);
        end
        check("so_sum32", 32'(sum), 32'd528);
        step();
        check("so_extra", ch(0), 32'd16);
        mode = 1'b0;
        step();
        check("toggle_out", ch(0), 32'd16);
        step();
        check("toggle_clr1", ch(0), 32'd16);
        step();
        check("toggle_clr2", ch(0), 32'd17);

        // Asynchronous reset with a sample pending.
        ce = 1'b0;
        in_valid = 1'b1;
        in_data  = {10'h3FF, 10'h3FF, 10'h3FF};
        ce = 1'b1;
        step();
        in_valid = 1'b0;
        ce = 1'b0;
        check("pre_rst_stb", 32'(out_stb), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out", 32'(out), 32'd0);
        check("mid_rst_stb", 32'(out_stb), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        step();
        reset = 1'b0;
        ce = 1'b1;
        step();
        check("post_rst_out", 32'(out), 32'd0);
        check("post_rst_stb", 32'(out_stb), 32'd1);
        step();
        check("post_rst_discard", 32'(out), 32'd0);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_sd_dac.md
# vector_sd_dac

Parametrised multi-channel sigma-delta requantiser for vector-display outputs. Each channel takes a wide unsigned sample, for example the 10-bit X/Y beam DAC words, and drives a narrower R-2R ladder, for example 6 bits. The narrower output is noise-shaped so that its time-average equals the input. The block sits between the game core's vector DAC outputs and the VGA pin registers under MISTER_VECTOR. It adds the following per channel:

- a valid/ready sample handshake with one-deep buffering;
- a clock-enable modulation rate;
- selectable first-order or second-order (MASH 1-1) shaping;
- blanking.

## Interface
- CHANNELS, 3: number of independent channels.
- IN_W, 10: input sample width. Unsigned.
- OUT_W, 6: output code width. Requires IN_W > OUT_W. FRAC_W = IN_W-OUT_W.
- clk  in  1: sole clock.
- reset  in  1: asynchronous, active-high. Clears all state.
- ce  in  1: modulator tick. The modulator advances only on cycles where ce=1.
- mode  in  1: 0 = first order, 1 = second order (MASH 1-1).
- blank  in  CHANNELS: per-channel blank. Forces that channel's output to 0.
- in_valid  in  1: sample vector offered.
- in_ready  out  1: pending buffer free. Registered.
- in_data  in  CHANNELS*IN_W: channel k occupies bits [k*IN_W +: IN_W].
- out  out  CHANNELS*OUT_W: registered output codes. Channel k occupies bits [k*OUT_W +: OUT_W].
- out_stb  out  1: one-cycle pulse registered together with each output update.

## Operation
**Buffers**
- The block holds a pending vector (pend, with flag pend_full) and a current vector (cur).
- Accept: in_valid & in_ready. The sample is written to pend and pend_full is set.
- in_ready = !pend_full, held in a register.
- On each ce: if pend_full, then cur <= pend and pend_full is cleared. The modulator then uses the updated cur on the following ce.
- There is no bypass. A sample accepted in the same cycle as a ce lands in pend and is applied at the next ce.

**Per channel, on each ce.** coarse = cur[IN_W-1:FRAC_W]; frac = cur[FRAC_W-1:0].
- First order:
  - s1 = acc1 + frac, computed in FRAC_W+1 bits.
  - c1 = s1 MSB.
  - acc1 <= s1 low bits.
  - Output = coarse + c1.
- Second order:
  - acc1 and c1 as in first order.
  - s2 = acc2 + (new acc1); c2 = s2 MSB; acc2 <= s2 low bits.
  - d = c1 + c2 - c2_prev, range -1..+2; then c2_prev <= c2.
  - Output = coarse + d.
- Saturation: the output is clamped to [0, 2^OUT_W-1] using signed arithmetic at least OUT_W+2 bits wide.
- Blanking: if blank[k]=1, out[k] <= 0 and that channel's acc1, acc2 and c2_prev are held. Shaping resumes seamlessly when blank drops.
- Mode change: if the mode sampled at this ce differs from the mode registered at the previous ce, all acc1, acc2 and c2_prev are cleared first. Output for that ce is coarse, with no correction term.
- On cycles where ce=0, out, the accumulators and out_stb=0 are all held.

## Timing
- Reset state: out=0, out_stb=0, in_ready=1, pend_full=0, cur=0, pend=0, all accumulators=0, registered mode=0.
- Latency:
  - A sample accepted in cycle t is moved to cur at the first ce in a cycle ≥ t+1.
  - Its first modulated output appears in out one cycle after the ce that first uses it.
  - With ce held at 1, a sample accepted in cycle t first affects out in cycle t+3.
- in_ready:
  - drops in the cycle after an accept;
  - rises in the cycle after the ce that empties pend.
- Backpressure: the source must hold in_valid and in_data until accepted. Data is never dropped or overwritten.
- Reset mid-operation: everything returns to the reset state immediately (asynchronously). A pending sample is discarded.

## Test plan
- **Reset**: assert reset mid-stream.
  - Required: out=0, out_stb=0 and in_ready=1 within the reset cycle.
  - Required: the first ce after release outputs 0 for every channel.
- **First order, exact average**: IN_W=10, OUT_W=6, ch0=0x105, mode=0, ce=1.
  - Required: over 16 consecutive ce, out[0]=17 exactly 5 times and 16 otherwise (sum 261).
  - Required: the pattern repeats every 16 ticks.
- **Saturation**:
  - ch1=0x3FF in mode 0 and mode 1: out[1]=63 on every ce, never wrapping.
  - ch2=0x000 in mode 1: out[2]=0, never negative-wrapping.
- **Handshake**: ce=0, offer A then B back-to-back.
  - Required: A is accepted, in_ready=0, and B is held.
  - Pulse ce once. Required: cur=A and in_ready=1 one cycle later; B is accepted the next cycle; A's output follows on the next ce.
- **Second order**: ch0=0x108, mode=1, ce=1.
  - Required: every output is in 15..18.
  - Required: the sum over 32 ce is 528±1.
  - Toggle mode. Required: the accumulators clear, and the output on that ce is exactly 16.
- **Blank**: ch0=0x105, mode=0; blank[0]=1 for 7 ce, then 0.
  - Required: out[0]=0 during blank.
  - Required: the post-blank sequence continues from the pre-blank accumulator state, i.e. it equals the unblanked sequence with a 7-tick gap.
